// File: rtl/mem_pkg.sv
// Shared types for the memory port controller.
//   size_e  : access size encoding carried on req_size (3 is illegal).
//   state_e : controller FSM states, also visible on dbg_state.
package mem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_e;

endpackage

// File: rtl/load_align.sv
// Combinational load formatter: picks the addressed byte/half lane out of a
// RAM word and sign- or zero-extends it to 32 bits.
//   word     : raw 32-bit RAM word
//   offset   : byte offset within the word (addr[1:0])
//   size     : size_e encoding; anything not byte/half is treated as word
//   unsigned : 1 = zero-extend, 0 = sign-extend
//   result   : right-aligned, extended load data
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        byte_sign;
  logic        half_sign;

  assign byte_v    = word[{offset, 3'b000} +: 8];
  // Halves are always 2-byte aligned, so only offset[1] selects the lane.
  assign half_v    = offset[1] ? word[31:16] : word[15:0];
  assign byte_sign = byte_v[7] & ~is_unsigned;
  assign half_sign = half_v[15] & ~is_unsigned;

  always_comb begin
    result = word;
    case (size_e'(size))
      SIZE_BYTE: result = {{24{byte_sign}}, byte_v};
      SIZE_HALF: result = {{16{half_sign}}, half_v};
      default:   result = word;
    endcase
  end

endmodule

// File: rtl/mem_port_ctrl.sv
// Single-port load/store controller between a CPU request port and a
// 32-bit synchronous RAM with per-byte write enables.
//   clk, rst                     : clock, synchronous active-high reset
//   req_valid/req_ready          : request handshake
//   req_we/req_size/req_unsigned : store flag, access size, load extension
//   req_addr/req_wdata           : byte address, right-aligned store data
//   rsp_valid/rsp_rdata/rsp_err  : one-cycle completion with data/error
//   ram_rd/ram_we/ram_addr       : RAM read enable, byte enables, word address
//   ram_data/ram_out             : RAM write data (lane-replicated), read data
//   dbg_state                    : current FSM state (state_e encoding)
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE outside reset; the CPU holds its request
// stable until it transfers. Every accepted request produces exactly one
// rsp_valid pulse (stores/errors one cycle later, loads two) unless rst
// intervenes, in which case the request is dropped silently.
module mem_port_ctrl
  import mem_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 13,
  parameter int RAM_BUS_WIDTH  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [1:0]                req_size,
  input  logic                      req_unsigned,
  input  logic [31:0]               req_addr,
  input  logic [31:0]               req_wdata,
  output logic                      rsp_valid,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_err,
  output logic                      ram_rd,
  output logic [3:0]                ram_we,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic [RAM_BUS_WIDTH-1:0]  ram_data,
  input  logic [RAM_BUS_WIDTH-1:0]  ram_out,
  output logic [1:0]                dbg_state
);

  state_e      state, state_nxt;
  logic        accept;
  logic        align_ok;
  logic        range_ok;
  logic        legal;
  logic [1:0]  lat_off;
  logic [1:0]  lat_size;
  logic        lat_uns;
  logic [31:0] load_data;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == RESP);
  assign dbg_state = state;
  assign ram_addr  = req_addr[RAM_ADDR_WIDTH+1:2];

  always_comb begin
    align_ok = 1'b0;
    case (size_e'(req_size))
      SIZE_BYTE: align_ok = 1'b1;
      SIZE_HALF: align_ok = !req_addr[0];
      SIZE_WORD: align_ok = (req_addr[1:0] == 2'b00);
      default:   align_ok = 1'b0;
    endcase
  end

  // Bytes above the RAM's footprint must be zero; there is no aliasing.
  assign range_ok = (req_addr[31:RAM_ADDR_WIDTH+2] == '0);
  assign legal    = align_ok && range_ok;

  // Stores are replicated to every lane so the byte enables alone pick the
  // destination bytes.
  always_comb begin
    ram_data = req_wdata;
    case (size_e'(req_size))
      SIZE_BYTE: ram_data = {4{req_wdata[7:0]}};
      SIZE_HALF: ram_data = {2{req_wdata[15:0]}};
      default:   ram_data = req_wdata;
    endcase
  end

  always_comb begin
    state_nxt = state;
    ram_rd    = 1'b0;
    ram_we    = 4'b0000;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!legal) begin
            state_nxt = RESP;
          end else if (req_we) begin
            state_nxt = RESP;
            case (size_e'(req_size))
              SIZE_BYTE: ram_we = 4'b0001 << req_addr[1:0];
              SIZE_HALF: ram_we = 4'b0011 << req_addr[1:0];
              default:   ram_we = 4'b1111;
            endcase
          end else begin
            state_nxt = RD_WAIT;
            ram_rd    = 1'b1;
          end
        end
      end
      RD_WAIT: state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  load_align u_load_align (
    .word        (ram_out),
    .offset      (lat_off),
    .size        (lat_size),
    .is_unsigned (lat_uns),
    .result      (load_data)
  );

  // Response registers change only when a response is being produced, so
  // they hold their previous value while rsp_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      lat_off   <= '0;
      lat_size  <= '0;
      lat_uns   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept && (!legal || req_we)) begin
        rsp_err   <= !legal;
        rsp_rdata <= '0;
      end
      if (accept && legal && !req_we) begin
        lat_off  <= req_addr[1:0];
        lat_size <= req_size;
        lat_uns  <= req_unsigned;
      end
      if (state == RD_WAIT) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl with a behavioural 8K x 32 RAM.
module tb_mem_port_ctrl;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        ram_rd;
  logic [3:0]  ram_we;
  logic [12:0] ram_addr;
  logic [31:0] ram_data;
  logic [31:0] ram_out;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  mem_port_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .ram_rd       (ram_rd),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_data     (ram_data),
    .ram_out      (ram_out),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- RAM model ----------------
  logic [31:0] mem [8192];
  logic [31:0] ram_q;
  assign ram_out = ram_q;

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = '0;
    ram_q = '0;
  end

  always @(posedge clk) begin
    if (ram_rd) ram_q <= mem[ram_addr];
    if (ram_we[0]) mem[ram_addr][7:0]   <= ram_data[7:0];
    if (ram_we[1]) mem[ram_addr][15:8]  <= ram_data[15:8];
    if (ram_we[2]) mem[ram_addr][23:16] <= ram_data[23:16];
    if (ram_we[3]) mem[ram_addr][31:24] <= ram_data[31:24];
  end

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_rd;
    logic [3:0]  exp_we;
    logic [12:0] exp_addr;
    logic [31:0] exp_data;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string name, input logic we, input logic [1:0] size,
                     input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic exp_rd, input logic [3:0] exp_we, input logic [12:0] exp_addr,
                     input logic [31:0] exp_data, input logic exp_err,
                     input logic [31:0] exp_rdata, input int exp_lat);
    vec_t v;
    v.name = name; v.we = we; v.size = size; v.uns = uns; v.addr = addr;
    v.wdata = wdata; v.exp_rd = exp_rd; v.exp_we = exp_we; v.exp_addr = exp_addr;
    v.exp_data = exp_data; v.exp_err = exp_err; v.exp_rdata = exp_rdata;
    v.exp_lat = exp_lat;
    vq.push_back(v);
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_vec(input vec_t v);
    int lat;
    @(negedge clk);
    chk({v.name, " ready"}, {31'b0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_we       = v.we;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    #1;
    chk({v.name, " ram_rd"}, {31'b0, ram_rd}, {31'b0, v.exp_rd});
    chk({v.name, " ram_we"}, {28'b0, ram_we}, {28'b0, v.exp_we});
    if (v.exp_rd || v.exp_we != 4'b0000)
      chk({v.name, " ram_addr"}, {19'b0, ram_addr}, {19'b0, v.exp_addr});
    if (v.exp_we != 4'b0000)
      chk({v.name, " ram_data"}, ram_data, v.exp_data);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 5) begin
      @(negedge clk);
      lat++;
    end
    chk({v.name, " latency"}, lat, v.exp_lat);
    if (rsp_valid) begin
      chk({v.name, " rsp_err"}, {31'b0, rsp_err}, {31'b0, v.exp_err});
      chk({v.name, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
      chk({v.name, " ready in RESP"}, {31'b0, req_ready}, 32'd0);
      @(negedge clk);
      chk({v.name, " rsp_valid drop"}, {31'b0, rsp_valid}, 32'd0);
      chk({v.name, " rdata hold"}, rsp_rdata, v.exp_rdata);
      chk({v.name, " err hold"}, {31'b0, rsp_err}, {31'b0, v.exp_err});
      chk({v.name, " ready after RESP"}, {31'b0, req_ready}, 32'd1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vec_t v;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

    // Requests during reset are ignored.
    repeat (2) @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h10;
    #1;
    chk("reset ready", {31'b0, req_ready}, 32'd0);
    chk("reset ram_rd", {31'b0, ram_rd}, 32'd0);
    chk("reset ram_we", {28'b0, ram_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    #1;
    chk("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'd0);
    chk("reset state", {30'b0, dbg_state}, 32'(IDLE));
    chk("reset ready out", {31'b0, req_ready}, 32'd1);

    //   name          we size uns addr          wdata         rd we       addr     data          err rdata        lat
    add("st_w 10",     1, 2, 0, 32'h10,   32'hDEADBEEF, 0, 4'b1111, 13'h4,    32'hDEADBEEF, 0, 32'h0,        1);
    add("ld_w 10",     0, 2, 0, 32'h10,   32'h0,        1, 4'b0000, 13'h4,    32'h0,        0, 32'hDEADBEEF, 2);
    add("st_w 10 b",   1, 2, 0, 32'h10,   32'h80FF1234, 0, 4'b1111, 13'h4,    32'h80FF1234, 0, 32'h0,        1);
    add("ld_b s 13",   0, 0, 0, 32'h13,   32'h0,        1, 4'b0000, 13'h4,    32'h0,        0, 32'hFFFFFF80, 2);
    add("ld_b u 13",   0, 0, 1, 32'h13,   32'h0,        1, 4'b0000, 13'h4,    32'h0,        0, 32'h00000080, 2);
    add("ld_b s 11",   0, 0, 0, 32'h11,   32'h0,        1, 4'b0000, 13'h4,    32'h0,        0, 32'h00000012, 2);
    add("st_h 22",     1, 1, 0, 32'h22,   32'h0000ABCD, 0, 4'b1100, 13'h8,    32'hABCDABCD, 0, 32'h0,        1);
    add("ld_h s 22",   0, 1, 0, 32'h22,   32'h0,        1, 4'b0000, 13'h8,    32'h0,        0, 32'hFFFFABCD, 2);
    add("ld_h u 22",   0, 1, 1, 32'h22,   32'h0,        1, 4'b0000, 13'h8,    32'h0,        0, 32'h0000ABCD, 2);
    add("st_b 21",     1, 0, 0, 32'h21,   32'hFFFFFF5A, 0, 4'b0010, 13'h8,    32'h5A5A5A5A, 0, 32'h0,        1);
    add("ld_w 20",     0, 2, 0, 32'h20,   32'h0,        1, 4'b0000, 13'h8,    32'h0,        0, 32'hABCD5A00, 2);
    add("ld_h s 20",   0, 1, 0, 32'h20,   32'h0,        1, 4'b0000, 13'h8,    32'h0,        0, 32'h00005A00, 2);
    add("st_w top",    1, 2, 0, 32'h7FFC, 32'h01020304, 0, 4'b1111, 13'h1FFF, 32'h01020304, 0, 32'h0,        1);
    add("ld_b u top",  0, 0, 1, 32'h7FFF, 32'h0,        1, 4'b0000, 13'h1FFF, 32'h0,        0, 32'h00000001, 2);
    add("ld_w 10 pre", 0, 2, 0, 32'h10,   32'h0,        1, 4'b0000, 13'h4,    32'h0,        0, 32'h80FF1234, 2);
    add("err ld_w 11", 0, 2, 0, 32'h11,   32'h0,        0, 4'b0000, 13'h0,    32'h0,        1, 32'h0,        1);
    add("err ld_h 03", 0, 1, 0, 32'h03,   32'h0,        0, 4'b0000, 13'h0,    32'h0,        1, 32'h0,        1);
    add("err size3",   0, 3, 0, 32'h00,   32'h0,        0, 4'b0000, 13'h0,    32'h0,        1, 32'h0,        1);
    add("ld_w ok",     0, 2, 0, 32'h10,   32'h0,        1, 4'b0000, 13'h4,    32'h0,        0, 32'h80FF1234, 2);
    add("err rng ld",  0, 2, 0, 32'h8000, 32'h0,        0, 4'b0000, 13'h0,    32'h0,        1, 32'h0,        1);
    add("err st_h 01", 1, 1, 0, 32'h01,   32'h1111,     0, 4'b0000, 13'h0,    32'h0,        1, 32'h0,        1);
    add("err rng st",  1, 2, 0, 32'h8004, 32'h2222,     0, 4'b0000, 13'h0,    32'h0,        1, 32'h0,        1);

    foreach (vq[i]) run_vec(vq[i]);

    // Illegal stores must not have touched the RAM.
    chk("no write by err st_h", mem[0], 32'h0);

    // Reset while a load waits for RAM data: response dropped.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h20;
    #1;
    chk("abort ram_rd", {31'b0, ram_rd}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort in RD_WAIT", {30'b0, dbg_state}, 32'(RD_WAIT));
    rst = 1'b1;
    #1;
    chk("abort ready in rst", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    chk("abort state", {30'b0, dbg_state}, 32'(IDLE));
    chk("abort rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("abort rdata cleared", rsp_rdata, 32'd0);
    rst = 1'b0;
    #1;
    chk("abort ready after rst", {31'b0, req_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort no rsp", {31'b0, rsp_valid}, 32'd0);
    end

    // RAM contents survive reset.
    v.name = "ld_w post rst"; v.we = 0; v.size = 2; v.uns = 0; v.addr = 32'h20;
    v.wdata = 0; v.exp_rd = 1; v.exp_we = 0; v.exp_addr = 13'h8; v.exp_data = 0;
    v.exp_err = 0; v.exp_rdata = 32'hABCD5A00; v.exp_lat = 2;
    run_vec(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
